fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control stage. Owns the PC. Issues word fetches to instruction memory over a req/ready handshake and presents instr_d/pc_plus4_d/valid_d to decode. Honours decode-side stalls via a one-entry skid buffer and accepts branch/jump redirects from ID, squashing wrong-path instructions (no delay slot).

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The master modport is the fetch stage; slave is the memory/decode environment.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  modport master (
    output imem_req, imem_addr, instr_d, pc_plus4_d, valid_d,
    input  imem_ready, imem_rdata, stall_d, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_d, pc_plus4_d, valid_d,
    output imem_ready, imem_rdata, stall_d, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, one-entry skid buffer, IF/ID register, redirect squash.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count/squash_count outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   squash_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  state_t      state_r;
  logic        req_r;
  logic [31:0] pc_r;
  logic [31:0] target_r;
  logic [31:0] instr_r;
  logic [31:0] pc4_r;
  logic        valid_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_pc4_r;

  logic        hs_s;
  logic [31:0] redirect_tgt_s;
  logic [31:0] pc_inc_s;

  // Handshake detect, aligned redirect target and wrapping PC increment
  always_comb begin
    hs_s           = req_r & bus.imem_ready;
    redirect_tgt_s = bus.redirect_pc & 32'hFFFF_FFFC;
    pc_inc_s       = pc_r + 32'd4;
  end

  // Sequencer, PC, skid buffer and IF/ID register; redirect outranks stall everywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_r        <= 1'b0;
      pc_r         <= RESET_PC_W;
      target_r     <= 32'd0;
      instr_r      <= 32'd0;
      pc4_r        <= 32'd0;
      valid_r      <= 1'b0;
      skid_instr_r <= 32'd0;
      skid_pc4_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.redirect) begin
            pc_r <= redirect_tgt_s;
          end
          state_r <= FETCH;
          req_r   <= 1'b1;
        end
        FETCH: begin
          if (bus.redirect) begin
            valid_r <= 1'b0;
            if (hs_s) begin
              pc_r <= redirect_tgt_s;
            end else begin
              // request is still in flight: let it finish on the old address
              target_r <= redirect_tgt_s;
              state_r  <= DRAIN;
            end
          end else if (hs_s) begin
            if (bus.stall_d) begin
              skid_instr_r <= bus.imem_rdata;
              skid_pc4_r   <= pc_inc_s;
              state_r      <= HOLD;
              req_r        <= 1'b0;
            end else begin
              instr_r <= bus.imem_rdata;
              pc4_r   <= pc_inc_s;
              valid_r <= 1'b1;
              pc_r    <= pc_inc_s;
            end
          end else if (!bus.stall_d) begin
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.redirect) begin
            valid_r <= 1'b0;
            pc_r    <= redirect_tgt_s;
            state_r <= FETCH;
            req_r   <= 1'b1;
          end else if (!bus.stall_d) begin
            instr_r <= skid_instr_r;
            pc4_r   <= skid_pc4_r;
            valid_r <= 1'b1;
            pc_r    <= skid_pc4_r;
            state_r <= FETCH;
            req_r   <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.redirect) begin
            target_r <= redirect_tgt_s;
            valid_r  <= 1'b0;
          end else if (hs_s) begin
            pc_r    <= target_r;
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.instr_d    = instr_r;
  assign bus.pc_plus4_d = pc4_r;
  assign bus.valid_d    = valid_r;

`ifdef FETCH_PERF_CNT_EN
  logic        squash_s;
  logic [31:0] fetch_cnt_r;
  logic [31:0] squash_cnt_r;

  // A squash is any completed fetch or skid entry whose instruction never reaches decode
  always_comb begin
    squash_s = 1'b0;
    case (state_r)
      FETCH:   squash_s = hs_s & bus.redirect;
      HOLD:    squash_s = bus.redirect;
      DRAIN:   squash_s = hs_s;
      default: squash_s = 1'b0;
    endcase
  end

  // Wrapping performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r  <= 32'd0;
      squash_cnt_r <= 32'd0;
    end else begin
      if (hs_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end
      if (squash_s) begin
        squash_cnt_r <= squash_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_count  = fetch_cnt_r;
  assign squash_count = squash_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_fetch_stage;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fetch_stage_if if0 ();
  fetch_stage_if if1 ();

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign if0.imem_rdata = memf(if0.imem_addr);
  assign if1.imem_rdata = memf(if1.imem_addr);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc0, sc0, fc1, sc1;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc0), .squash_count(sc0)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fc1), .squash_count(sc1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of dut0: what decode and memory should see, tracked as plain facts
  bit          m_started, m_req, m_parked, m_squash, m_valid;
  logic [31:0] m_pc, m_tgt, m_park_i, m_park_pc4, m_instr, m_pc4;
  logic [31:0] m_fc, m_sc;

  task automatic m_reset();
    m_started = 1'b0; m_req = 1'b0; m_parked = 1'b0; m_squash = 1'b0; m_valid = 1'b0;
    m_pc = 32'h0; m_tgt = 32'h0; m_park_i = 32'h0; m_park_pc4 = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  task automatic m_step();
    bit          hs;
    logic [31:0] tgt;
    hs  = m_req && if0.imem_ready;
    tgt = {if0.redirect_pc[31:2], 2'b00};
    if (hs) m_fc = m_fc + 32'd1;
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
      if (if0.redirect) m_pc = tgt;
    end else if (if0.redirect) begin
      m_valid = 1'b0;
      if (m_parked) begin
        m_parked = 1'b0; m_pc = tgt; m_req = 1'b1; m_sc = m_sc + 32'd1;
      end else if (m_squash) begin
        m_tgt = tgt;
        if (hs) m_sc = m_sc + 32'd1;
      end else if (hs) begin
        m_pc = tgt; m_sc = m_sc + 32'd1;
      end else begin
        m_squash = 1'b1; m_tgt = tgt;
      end
    end else if (m_parked) begin
      if (!if0.stall_d) begin
        m_instr = m_park_i; m_pc4 = m_park_pc4; m_valid = 1'b1;
        m_pc = m_park_pc4; m_parked = 1'b0; m_req = 1'b1;
      end
    end else if (m_squash) begin
      if (hs) begin
        m_squash = 1'b0; m_pc = m_tgt; m_sc = m_sc + 32'd1;
      end
    end else if (hs) begin
      if (if0.stall_d) begin
        m_park_i = memf(m_pc); m_park_pc4 = m_pc + 32'd4; m_parked = 1'b1; m_req = 1'b0;
      end else begin
        m_instr = memf(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (!if0.stall_d) begin
      m_valid = 1'b0;
    end
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(posedge clk) cyc++;

  // Every-cycle comparison of dut0 against the model
  always @(negedge clk) begin
    check("req",   {31'd0, if0.imem_req}, {31'd0, m_req});
    check("addr",  if0.imem_addr, m_pc);
    check("valid", {31'd0, if0.valid_d}, {31'd0, m_valid});
    check("instr", if0.instr_d, m_instr);
    check("pc4",   if0.pc_plus4_d, m_pc4);
`ifdef FETCH_PERF_CNT_EN
    check("fcnt", fc0, m_fc);
    check("scnt", sc0, m_sc);
`endif
  end

  logic [2:0] vec [16];

  initial begin
    vec = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b000, 3'b010, 3'b011, 3'b110,
            3'b001, 3'b101, 3'b001, 3'b100, 3'b010, 3'b011, 3'b001, 3'b001};
    if0.imem_ready = 1'b1; if0.stall_d = 1'b0; if0.redirect = 1'b0; if0.redirect_pc = 32'h0;
    if1.imem_ready = 1'b1; if1.stall_d = 1'b0; if1.redirect = 1'b0; if1.redirect_pc = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req",   {31'd0, if0.imem_req}, 32'd0);
    check("rst_valid", {31'd0, if0.valid_d}, 32'd0);
    check("rst_addr1", if1.imem_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    // sequential fetch, and the wrapping instance alongside
    @(negedge clk);
    check("t1_addr0", if0.imem_addr, 32'h0);
    check("t5_addr0", if1.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("t1_addr1", if0.imem_addr, 32'h4);
    check("t1_pc4_1", if0.pc_plus4_d, 32'h4);
    check("t1_ins_1", if0.instr_d, memf(32'h0));
    check("t5_addr1", if1.imem_addr, 32'hFFFF_FFFC);
    check("t5_pc4_1", if1.pc_plus4_d, 32'hFFFF_FFFC);
    @(negedge clk);
    check("t1_addr2", if0.imem_addr, 32'h8);
    check("t1_pc4_2", if0.pc_plus4_d, 32'h8);
    check("t5_addr2", if1.imem_addr, 32'h0);
    check("t5_pc4_2", if1.pc_plus4_d, 32'h0);
    check("t5_valid", {31'd0, if1.valid_d}, 32'd1);

    // stall at completion of addr 8
    if0.stall_d = 1'b1;
    @(negedge clk);
    check("t2_req_hold", {31'd0, if0.imem_req}, 32'd0);
    check("t2_ins_hold", if0.instr_d, memf(32'h4));
    repeat (2) @(negedge clk);
    check("t2_pc4_hold", if0.pc_plus4_d, 32'h8);
    if0.stall_d = 1'b0;
    @(negedge clk);
    check("t2_ins_rel", if0.instr_d, memf(32'h8));
    check("t2_pc4_rel", if0.pc_plus4_d, 32'hC);
    check("t2_addr_rel", if0.imem_addr, 32'hC);
    @(negedge clk);
    check("t2_ins_next", if0.instr_d, memf(32'hC));

    // redirect while memory is not ready
    if0.imem_ready = 1'b0; if0.redirect = 1'b1; if0.redirect_pc = 32'h40;
    @(negedge clk);
    if0.redirect = 1'b0;
    check("t3_addr_old", if0.imem_addr, 32'h10);
    check("t3_valid0", {31'd0, if0.valid_d}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_addr_wait", if0.imem_addr, 32'h10);
    if0.imem_ready = 1'b1;
    @(negedge clk);
    check("t3_addr_tgt", if0.imem_addr, 32'h40);
    check("t3_valid_drop", {31'd0, if0.valid_d}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("t3_squash", sc0, 32'd1);
`endif
    @(negedge clk);
    check("t3_ins_tgt", if0.instr_d, memf(32'h40));
    check("t3_pc4_tgt", if0.pc_plus4_d, 32'h44);

    // redirect coinciding with completion, unaligned target
    if0.redirect = 1'b1; if0.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    if0.redirect = 1'b0;
    check("t4_addr", if0.imem_addr, 32'h100);
    check("t4_valid0", {31'd0, if0.valid_d}, 32'd0);
    @(negedge clk);
    check("t4_ins", if0.instr_d, memf(32'h100));
    check("t4_pc4", if0.pc_plus4_d, 32'h104);

    // reset while draining
    if0.imem_ready = 1'b0; if0.redirect = 1'b1; if0.redirect_pc = 32'h200;
    @(negedge clk);
    if0.redirect = 1'b0;
    check("t6_in_drain", if0.imem_addr, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req",   {31'd0, if0.imem_req}, 32'd0);
    check("t6_addr",  if0.imem_addr, 32'h0);
    check("t6_valid", {31'd0, if0.valid_d}, 32'd0);
    check("t6_instr", if0.instr_d, 32'h0);
    check("t6_pc4",   if0.pc_plus4_d, 32'h0);
    @(negedge clk);
    if0.imem_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart", if0.imem_addr, 32'h0);
    check("t6_req1", {31'd0, if0.imem_req}, 32'd1);

    // mixed stall / ready / redirect sequence, checked by the model
    for (int i = 0; i < 16; i++) begin
      if0.redirect    = vec[i][2];
      if0.stall_d     = vec[i][1];
      if0.imem_ready  = vec[i][0];
      if0.redirect_pc = 32'h300 + 32'(i) * 32'd16;
      @(negedge clk);
    end
    if0.redirect = 1'b0; if0.stall_d = 1'b0; if0.imem_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
